wdt_rst_ctrl: RTL

Watchdog timeout consumer that sits directly downstream of the watchdog wrapper's WTO output. On a WTO rising edge it raises a CPU interrupt and opens a grace window for software to acknowledge. If the window expires unacknowledged, it issues a fixed-width system reset request, then holds off until WTO has been low for a set time. Saturating event counters are exposed for status readback.

---
 rtl/wdt_rst_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/wdt_rst_ctrl.sv
// wdt_rst_ctrl: watchdog timeout consumer -> CPU irq, then reset escalation.
// Optional build macro: WDT_GLITCH_FILTER_EN (3-sample qualified trigger).
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   wto_i        : watchdog timeout level (already synchronized)
//   irq_ack      : software acknowledge (pulse or level)
//   irq_o        : interrupt to CPU, high while in IRQ
//   sys_rst_req  : system reset request, high while in RESET
//   timeout_cnt  : saturating count of IRQ entries
//   reset_cnt    : saturating count of RESET entries
//   state_o      : IDLE=0, IRQ=1, RESET=2, HOLD=3
module wdt_rst_ctrl #(
    parameter int GRACE_CYC = 32,
    parameter int PULSE_CYC = 16,
    parameter int HOLD_CYC  = 8,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wto_i,
    input  logic             irq_ack,
    output logic             irq_o,
    output logic             sys_rst_req,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [CNT_W-1:0] reset_cnt,
    output logic [1:0]       state_o
);

    localparam int GW = $clog2(GRACE_CYC > 2 ? GRACE_CYC : 2);
    localparam int PW = $clog2(PULSE_CYC > 2 ? PULSE_CYC : 2);
    localparam int HW = $clog2(HOLD_CYC > 2 ? HOLD_CYC : 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IRQ   = 2'd1,
        S_RESET = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t        state;
    logic [GW-1:0] grace_cnt;
    logic [PW-1:0] pulse_cnt;
    logic [HW-1:0] hold_cnt;
    logic          trig;

`ifdef WDT_GLITCH_FILTER_EN
    // hist[0] is the previous sample, hist[2] three samples back.
    // Resets to all-ones so a level held across reset never qualifies.
    logic [2:0] wto_hist;

    always_ff @(posedge clk) begin
        if (rst) wto_hist <= 3'b111;
        else     wto_hist <= {wto_hist[1:0], wto_i};
    end

    assign trig = wto_i & wto_hist[0] & wto_hist[1] & ~wto_hist[2];
`else
    logic wto_q;

    always_ff @(posedge clk) begin
        if (rst) wto_q <= 1'b1;
        else     wto_q <= wto_i;
    end

    assign trig = wto_i & ~wto_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            grace_cnt   <= '0;
            pulse_cnt   <= '0;
            hold_cnt    <= '0;
            timeout_cnt <= '0;
            reset_cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (trig) begin
                        state     <= S_IRQ;
                        grace_cnt <= GW'(GRACE_CYC - 1);
                        if (timeout_cnt != '1)
                            timeout_cnt <= timeout_cnt + CNT_W'(1);
                    end
                end
                S_IRQ: begin
                    // Acknowledge takes priority over grace expiry.
                    if (irq_ack) begin
                        state <= S_IDLE;
                    end else if (grace_cnt == '0) begin
                        state     <= S_RESET;
                        pulse_cnt <= PW'(PULSE_CYC - 1);
                        if (reset_cnt != '1)
                            reset_cnt <= reset_cnt + CNT_W'(1);
                    end else begin
                        grace_cnt <= grace_cnt - GW'(1);
                    end
                end
                S_RESET: begin
                    if (pulse_cnt == '0) begin
                        state    <= S_HOLD;
                        hold_cnt <= '0;
                    end else begin
                        pulse_cnt <= pulse_cnt - PW'(1);
                    end
                end
                S_HOLD: begin
                    // Needs HOLD_CYC consecutive low samples of wto_i.
                    if (wto_i)
                        hold_cnt <= '0;
                    else if (hold_cnt == HW'(HOLD_CYC - 1))
                        state <= S_IDLE;
                    else
                        hold_cnt <= hold_cnt + HW'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign irq_o       = (state == S_IRQ);
    assign sys_rst_req = (state == S_RESET);
    assign state_o     = state;

endmodule
